// File: rtl/asic_crypto_top.sv
// ChaCha20 block engine: assembles the state from constants, key, nonce and counter, runs the
// block function one quarter-round per cycle and streams plaintext XOR keystream out.
module asic_crypto_top #(
  parameter int ROUNDS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic [31:0] in_state_word,
  input  logic        in_state_valid,
  output logic        in_state_ready,
  output logic [31:0] out_state_word,
  output logic        out_state_valid,
  input  logic        out_state_ready,
  input  logic        use_streamed_key,
  input  logic        use_streamed_nonce,
  input  logic        use_streamed_counter,
  input  logic [1:0]  chunk_type,
  input  logic        chunk_valid,
  input  logic [31:0] chunk,
  output logic [4:0]  chunk_index,
  output logic        chunk_request,
  output logic [1:0]  request_type,
  input  logic [31:0] trng_data,
  input  logic        trng_ready,
  output logic        trng_request
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD_KEY   = 3'd1,
    S_LOAD_NONCE = 3'd2,
    S_LOAD_CTR   = 3'd3,
    S_LOAD_DATA  = 3'd4,
    S_ROUNDS     = 3'd5,
    S_FINAL      = 3'd6,
    S_OUTPUT     = 3'd7
  } state_t;

  localparam logic [6:0] QR_LAST = 7'(ROUNDS * 4 - 1);

  state_t      state_r, state_nx_s;
  logic [4:0]  idx_r, idx_nx_s;
  logic [3:0]  wcnt_r;
  logic [6:0]  qr_cnt_r;
  logic [2:0]  sel_r, mode_s;
  logic [31:0] blk_ctr_r;
  logic [31:0] st_r   [16];
  logic [31:0] init_r [16];
  logic [31:0] data_r [16];
  logic [31:0] res_s  [16];
  logic        take_s, in_acc_s, out_acc_s;
  logic [31:0] load_word_s;
  logic [3:0]  qa_s, qb_s, qc_s, qd_s;
  logic [127:0] qr_s;

  function automatic logic [127:0] qr_f(input logic [31:0] a_i, input logic [31:0] b_i,
                                        input logic [31:0] c_i, input logic [31:0] d_i);
    logic [31:0] a, b, c, d;
    a = a_i + b_i; d = d_i ^ a; d = {d[15:0], d[31:16]};
    c = c_i + d;   b = b_i ^ c; b = {b[19:0], b[31:20]};
    a = a + b;     d = d ^ a;   d = {d[23:0], d[31:24]};
    c = c + d;     b = b ^ c;   b = {b[24:0], b[31:25]};
    return {a, b, c, d};
  endfunction

  // Column quarter-rounds first, then diagonals, within each double round.
  function automatic logic [15:0] qr_idx_f(input logic [2:0] sel);
    logic [15:0] idx;
    case (sel)
      3'd0:    idx = {4'd0, 4'd4, 4'd8,  4'd12};
      3'd1:    idx = {4'd1, 4'd5, 4'd9,  4'd13};
      3'd2:    idx = {4'd2, 4'd6, 4'd10, 4'd14};
      3'd3:    idx = {4'd3, 4'd7, 4'd11, 4'd15};
      3'd4:    idx = {4'd0, 4'd5, 4'd10, 4'd15};
      3'd5:    idx = {4'd1, 4'd6, 4'd11, 4'd12};
      3'd6:    idx = {4'd2, 4'd7, 4'd8,  4'd13};
      3'd7:    idx = {4'd3, 4'd4, 4'd9,  4'd14};
      default: idx = {4'd0, 4'd4, 4'd8,  4'd12};
    endcase
    return idx;
  endfunction

  // Source selection: live inputs while idle, latched copy once running.
  always_comb begin
    if (state_r == S_IDLE) mode_s = {use_streamed_counter, use_streamed_nonce, use_streamed_key};
    else                   mode_s = sel_r;
  end

  // Quarter-round operands and final keystream/XOR result.
  always_comb begin
    {qa_s, qb_s, qc_s, qd_s} = qr_idx_f(qr_cnt_r[2:0]);
    qr_s = qr_f(st_r[qa_s], st_r[qb_s], st_r[qc_s], st_r[qd_s]);
    for (int i = 0; i < 16; i++) res_s[i] = (st_r[i] + init_r[i]) ^ data_r[i];
  end

  assign in_acc_s  = in_state_valid && in_state_ready;
  assign out_acc_s = out_state_valid && out_state_ready;

  // State register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state_r <= S_IDLE;
    else       state_r <= state_nx_s;
  end

  // Next-state, load index and word-take decode.
  always_comb begin
    state_nx_s  = state_r;
    idx_nx_s    = idx_r;
    take_s      = 1'b0;
    load_word_s = chunk;
    case (state_r)
      S_IDLE: begin
        if (start) state_nx_s = S_LOAD_KEY;
        else       state_nx_s = S_IDLE;
      end
      S_LOAD_KEY: begin
        take_s      = mode_s[0] ? (chunk_valid && chunk_type == 2'd0) : trng_ready;
        load_word_s = mode_s[0] ? chunk : trng_data;
        if (take_s && idx_r == 5'd7) begin
          state_nx_s = S_LOAD_NONCE;
          idx_nx_s   = 5'd0;
        end else if (take_s) begin
          idx_nx_s = idx_r + 5'd1;
        end else begin
          idx_nx_s = idx_r;
        end
      end
      S_LOAD_NONCE: begin
        take_s      = mode_s[1] ? (chunk_valid && chunk_type == 2'd1) : trng_ready;
        load_word_s = mode_s[1] ? chunk : trng_data;
        if (take_s && idx_r == 5'd2) begin
          state_nx_s = mode_s[2] ? S_LOAD_CTR : S_LOAD_DATA;
          idx_nx_s   = 5'd0;
        end else if (take_s) begin
          idx_nx_s = idx_r + 5'd1;
        end else begin
          idx_nx_s = idx_r;
        end
      end
      S_LOAD_CTR: begin
        take_s = chunk_valid && chunk_type == 2'd2;
        if (take_s) state_nx_s = S_LOAD_DATA;
        else        state_nx_s = S_LOAD_CTR;
      end
      S_LOAD_DATA: begin
        if (in_acc_s && wcnt_r == 4'd15) state_nx_s = S_ROUNDS;
        else                             state_nx_s = S_LOAD_DATA;
      end
      S_ROUNDS: begin
        if (qr_cnt_r == QR_LAST) state_nx_s = S_FINAL;
        else                     state_nx_s = S_ROUNDS;
      end
      S_FINAL: state_nx_s = S_OUTPUT;
      S_OUTPUT: begin
        if (out_acc_s && wcnt_r == 4'd15) state_nx_s = S_IDLE;
        else                              state_nx_s = S_OUTPUT;
      end
      default: state_nx_s = S_IDLE;
    endcase
  end

  // Working state, data buffer, counters and block counter.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < 16; i++) begin
        st_r[i]   <= 32'd0;
        init_r[i] <= 32'd0;
        data_r[i] <= 32'd0;
      end
      idx_r     <= 5'd0;
      wcnt_r    <= 4'd0;
      qr_cnt_r  <= 7'd0;
      sel_r     <= 3'd0;
      blk_ctr_r <= 32'd0;
    end else begin
      idx_r <= idx_nx_s;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            st_r[0]  <= 32'h61707865;
            st_r[1]  <= 32'h3320646e;
            st_r[2]  <= 32'h79622d32;
            st_r[3]  <= 32'h6b206574;
            sel_r    <= mode_s;
            wcnt_r   <= 4'd0;
            qr_cnt_r <= 7'd0;
          end
        end
        S_LOAD_KEY:   if (take_s) st_r[4'd4 + idx_r[3:0]] <= load_word_s;
        S_LOAD_NONCE: begin
          if (take_s) st_r[4'd13 + idx_r[3:0]] <= load_word_s;
          if (take_s && idx_r == 5'd2 && !mode_s[2]) st_r[12] <= blk_ctr_r;
        end
        S_LOAD_CTR:   if (take_s) st_r[12] <= chunk;
        S_LOAD_DATA: begin
          if (in_acc_s) begin
            data_r[wcnt_r] <= in_state_word;
            wcnt_r         <= wcnt_r + 4'd1;
          end
          if (in_acc_s && wcnt_r == 4'd15) begin
            for (int i = 0; i < 16; i++) init_r[i] <= st_r[i];
          end
        end
        S_ROUNDS: begin
          {st_r[qa_s], st_r[qb_s], st_r[qc_s], st_r[qd_s]} <= qr_s;
          qr_cnt_r <= qr_cnt_r + 7'd1;
        end
        S_FINAL: for (int i = 0; i < 16; i++) data_r[i] <= res_s[i];
        S_OUTPUT: begin
          if (out_acc_s) wcnt_r <= wcnt_r + 4'd1;
          if (out_acc_s && wcnt_r == 4'd15) blk_ctr_r <= blk_ctr_r + 32'd1;
        end
        default: sel_r <= sel_r;
      endcase
    end
  end

  // Registered outputs, decoded from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      busy            <= 1'b0;
      done            <= 1'b0;
      in_state_ready  <= 1'b0;
      out_state_valid <= 1'b0;
      out_state_word  <= 32'd0;
      chunk_request   <= 1'b0;
      trng_request    <= 1'b0;
      request_type    <= 2'd0;
      chunk_index     <= 5'd0;
    end else begin
      busy            <= state_nx_s != S_IDLE;
      done            <= (state_r == S_OUTPUT) && (state_nx_s == S_IDLE);
      in_state_ready  <= state_nx_s == S_LOAD_DATA;
      out_state_valid <= state_nx_s == S_OUTPUT;
      chunk_request   <= (state_nx_s == S_LOAD_KEY && mode_s[0]) ||
                         (state_nx_s == S_LOAD_NONCE && mode_s[1]) || (state_nx_s == S_LOAD_CTR);
      trng_request    <= (state_nx_s == S_LOAD_KEY && !mode_s[0]) ||
                         (state_nx_s == S_LOAD_NONCE && !mode_s[1]);
      request_type    <= (state_nx_s == S_LOAD_NONCE) ? 2'd1 :
                         (state_nx_s == S_LOAD_CTR) ? 2'd2 : 2'd0;
      chunk_index     <= (state_nx_s == S_LOAD_KEY || state_nx_s == S_LOAD_NONCE ||
                          state_nx_s == S_LOAD_CTR) ? idx_nx_s : 5'd0;
      if (state_r == S_FINAL)
        out_state_word <= res_s[0];
      else if (state_r == S_OUTPUT && out_acc_s && wcnt_r != 4'd15)
        out_state_word <= data_r[wcnt_r + 4'd1];
      else
        out_state_word <= out_state_word;
    end
  end

endmodule

// File: tb/tb_asic_crypto_top.sv
// Scoreboard bench for asic_crypto_top: RFC 7539 vector, TRNG path, backpressure,
// internal counter progression and reset during the rounds.
module tb_asic_crypto_top;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, in_state_ready, out_state_valid, chunk_request, trng_request;
  logic [31:0] in_state_word = 32'd0;
  logic        in_state_valid = 1'b0;
  logic [31:0] out_state_word;
  logic        out_state_ready = 1'b1;
  logic        use_streamed_key = 1'b0, use_streamed_nonce = 1'b0, use_streamed_counter = 1'b0;
  logic [1:0]  chunk_type = 2'd0;
  logic        chunk_valid = 1'b0;
  logic [31:0] chunk = 32'd0;
  logic [4:0]  chunk_index;
  logic [1:0]  request_type;
  logic [31:0] trng_data = 32'd0;
  logic        trng_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  logic [31:0] exp_q [$];
  logic [31:0] tb_key [8];
  logic [31:0] tb_nonce [4];
  logic [31:0] tb_data [16];
  logic [31:0] tb_ctr_chunk = 32'd0;
  logic [31:0] exp_ctr = 32'd0;
  logic [31:0] m_x [16];
  logic        hold_pending = 1'b0;
  logic [31:0] hold_word = 32'd0;

  asic_crypto_top #(.ROUNDS(20)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .in_state_word(in_state_word), .in_state_valid(in_state_valid), .in_state_ready(in_state_ready),
    .out_state_word(out_state_word), .out_state_valid(out_state_valid),
    .out_state_ready(out_state_ready), .use_streamed_key(use_streamed_key),
    .use_streamed_nonce(use_streamed_nonce), .use_streamed_counter(use_streamed_counter),
    .chunk_type(chunk_type), .chunk_valid(chunk_valid), .chunk(chunk),
    .chunk_index(chunk_index), .chunk_request(chunk_request), .request_type(request_type),
    .trng_data(trng_data), .trng_ready(trng_ready), .trng_request(trng_request)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted output word and checks hold stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      if (done) done_cnt++;
      if (out_state_valid) begin
        if (hold_pending) check("out_hold", out_state_word, hold_word);
        if (out_state_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_output: got %h expected none", out_state_word);
          end else begin
            check("out_word", out_state_word, exp_q.pop_front());
          end
          hold_pending = 1'b0;
        end else begin
          hold_pending = 1'b1;
          hold_word = out_state_word;
        end
      end else begin
        hold_pending = 1'b0;
      end
    end else begin
      hold_pending = 1'b0;
    end
  end

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  task automatic m_qr(input int a, input int b, input int c, input int d);
    m_x[a] = m_x[a] + m_x[b]; m_x[d] = rotl(m_x[d] ^ m_x[a], 16);
    m_x[c] = m_x[c] + m_x[d]; m_x[b] = rotl(m_x[b] ^ m_x[c], 12);
    m_x[a] = m_x[a] + m_x[b]; m_x[d] = rotl(m_x[d] ^ m_x[a], 8);
    m_x[c] = m_x[c] + m_x[d]; m_x[b] = rotl(m_x[b] ^ m_x[c], 7);
  endtask

  task automatic push_model(input logic [31:0] ctr);
    logic [31:0] init [16];
    init[0] = 32'h61707865; init[1] = 32'h3320646e;
    init[2] = 32'h79622d32; init[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) init[4 + i] = tb_key[i];
    init[12] = ctr;
    for (int i = 0; i < 3; i++) init[13 + i] = tb_nonce[i];
    m_x = init;
    for (int r = 0; r < 10; r++) begin
      m_qr(0, 4, 8, 12); m_qr(1, 5, 9, 13); m_qr(2, 6, 10, 14); m_qr(3, 7, 11, 15);
      m_qr(0, 5, 10, 15); m_qr(1, 6, 11, 12); m_qr(2, 7, 8, 13); m_qr(3, 4, 9, 14);
    end
    for (int i = 0; i < 16; i++) exp_q.push_back((m_x[i] + init[i]) ^ tb_data[i]);
  endtask

  task automatic set_rfc_key_nonce();
    tb_key[0] = 32'h03020100; tb_key[1] = 32'h07060504; tb_key[2] = 32'h0b0a0908;
    tb_key[3] = 32'h0f0e0d0c; tb_key[4] = 32'h13121110; tb_key[5] = 32'h17161514;
    tb_key[6] = 32'h1b1a1918; tb_key[7] = 32'h1f1e1d1c;
    tb_nonce[0] = 32'h09000000; tb_nonce[1] = 32'h4a000000;
    tb_nonce[2] = 32'h00000000; tb_nonce[3] = 32'h00000000;
  endtask

  task automatic do_start(input logic sk, input logic sn, input logic sc);
    use_streamed_key = sk; use_streamed_nonce = sn; use_streamed_counter = sc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  // Serves chunk/TRNG requests and feeds the 16 data words; optionally injects a wrong chunk type.
  task automatic load_phase(input bit bad, output int trng_cycles);
    int  di = 0;
    int  guard = 0;
    bit  injected = 1'b0;
    bit  bad_pending = 1'b0;
    trng_cycles = 0;
    while (di < 16 && guard < 500) begin
      chunk_valid = 1'b0; chunk_type = 2'd0; chunk = 32'd0; in_state_valid = 1'b0;
      if (trng_request && !in_state_ready) trng_cycles++;
      if (chunk_request) begin
        chunk_valid = 1'b1;
        if (bad && !injected && request_type == 2'd0 && chunk_index == 5'd3) begin
          chunk_type = 2'd1; chunk = 32'hbad0bad0; injected = 1'b1; bad_pending = 1'b1;
        end else begin
          chunk_type = request_type;
          case (request_type)
            2'd0:    chunk = tb_key[chunk_index[2:0]];
            2'd1:    chunk = tb_nonce[chunk_index[1:0]];
            2'd2:    chunk = tb_ctr_chunk;
            default: chunk = 32'd0;
          endcase
        end
      end
      if (in_state_ready) begin
        in_state_valid = 1'b1;
        in_state_word = tb_data[di];
      end
      @(posedge clk); #1;
      if (in_state_valid) di++;
      if (bad_pending) begin
        check("bad_type_index", 32'(chunk_index), 32'd3);
        check("bad_type_reqtype", 32'(request_type), 32'd0);
        bad_pending = 1'b0;
      end
      guard++;
    end
    chunk_valid = 1'b0; in_state_valid = 1'b0;
    check("load_complete", 32'(di), 32'd16);
  endtask

  // Drains the output words, optionally toggling ready, and checks for a single done pulse.
  task automatic drain_phase(input bit bp);
    int guard = 0;
    int d0 = done_cnt;
    while ((exp_q.size() != 0 || done_cnt == d0) && guard < 400) begin
      out_state_ready = bp ? ~out_state_ready : 1'b1;
      @(posedge clk); #1;
      guard++;
    end
    out_state_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("drain_in_time", 32'(guard < 400), 32'd1);
    check("done_pulses", 32'(done_cnt - d0), 32'd1);
    check("busy_after_done", 32'(busy), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int tc;
    for (int i = 0; i < 16; i++) tb_data[i] = 32'd0;
    set_rfc_key_nonce();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_in_ready", 32'(in_state_ready), 32'd0);
    check("rst_out_valid", 32'(out_state_valid), 32'd0);
    check("rst_chunk_req", 32'(chunk_request), 32'd0);
    check("rst_trng_req", 32'(trng_request), 32'd0);
    check("rst_chunk_index", 32'(chunk_index), 32'd0);
    check("rst_req_type", 32'(request_type), 32'd0);
    check("rst_out_word", out_state_word, 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;

    // RFC 7539 block, everything streamed, junk on the TRNG, wrong-type chunk, backpressure.
    trng_ready = 1'b1; trng_data = 32'h5555aaaa; tb_ctr_chunk = 32'd1;
    exp_q.push_back(32'he4e7f110); exp_q.push_back(32'h15593bd1);
    exp_q.push_back(32'h1fdd0f50); exp_q.push_back(32'hc47120a3);
    exp_q.push_back(32'hc7f4d1c7); exp_q.push_back(32'h0368c033);
    exp_q.push_back(32'h9aaa2204); exp_q.push_back(32'h4e6cd4c3);
    exp_q.push_back(32'h466482d2); exp_q.push_back(32'h09aa9f07);
    exp_q.push_back(32'h05d7c214); exp_q.push_back(32'ha2028bd9);
    exp_q.push_back(32'hd19c12b5); exp_q.push_back(32'hb94e16de);
    exp_q.push_back(32'he883d0cb); exp_q.push_back(32'h4e3c50a2);
    do_start(1'b1, 1'b1, 1'b1);
    load_phase(1'b1, tc);
    drain_phase(1'b1);
    exp_ctr = exp_ctr + 32'd1;

    // TRNG for key and nonce, internal counter.
    trng_ready = 1'b1; trng_data = 32'hdeadbeef;
    for (int i = 0; i < 8; i++) tb_key[i] = 32'hdeadbeef;
    for (int i = 0; i < 4; i++) tb_nonce[i] = 32'hdeadbeef;
    for (int i = 0; i < 16; i++) tb_data[i] = 32'h01010101 * 32'(i);
    push_model(exp_ctr);
    do_start(1'b0, 1'b0, 1'b0);
    load_phase(1'b0, tc);
    check("trng_req_cycles", 32'(tc), 32'd11);
    drain_phase(1'b0);
    exp_ctr = exp_ctr + 32'd1;

    // Same block twice on the internal counter; start pulsed while busy must be ignored.
    trng_data = 32'h12345678;
    set_rfc_key_nonce();
    for (int i = 0; i < 16; i++) tb_data[i] = 32'd0;
    push_model(exp_ctr);
    do_start(1'b1, 1'b1, 1'b0);
    load_phase(1'b0, tc);
    start = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    start = 1'b0;
    drain_phase(1'b0);
    exp_ctr = exp_ctr + 32'd1;
    push_model(exp_ctr);
    do_start(1'b1, 1'b1, 1'b0);
    load_phase(1'b0, tc);
    drain_phase(1'b1);
    exp_ctr = exp_ctr + 32'd1;

    // Reset during the rounds: abort with no output, counter back to zero.
    do_start(1'b0, 1'b0, 1'b0);
    load_phase(1'b0, tc);
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out_valid", 32'(out_state_valid), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_ctr = 32'd0;
    repeat (120) @(posedge clk);
    #1;
    check("abort_idle_busy", 32'(busy), 32'd0);
    push_model(exp_ctr);
    do_start(1'b1, 1'b1, 1'b0);
    load_phase(1'b0, tc);
    drain_phase(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
